// File: rtl/exibe_sequencia_pkg.sv
// -----------------------------------------------------------------------------
// exibe_sequencia_pkg
//   Shared definitions for the sequence presenter of the memory game.
//   State codes are fixed values so that the control unit and any bench decode
//   db_estado identically. Also provides the timer width helper.
// -----------------------------------------------------------------------------
package exibe_sequencia_pkg;

    // State codes as seen on db_estado
    typedef enum logic [3:0] {
        OCIOSO  = 4'h0,
        CARREGA = 4'h1,
        MOSTRA  = 4'h2,
        APAGA   = 4'h3,
        PROXIMO = 4'h4,
        FIM     = 4'hF
    } estado_t;

    // Code reported on db_estado when the state register holds an unused value
    localparam logic [3:0] EST_INVALIDO = 4'hE;

    // Timer width: enough bits to hold 0..max(T_ON,T_OFF)-1, never below one bit
    function automatic int largura_timer(input int t_on, input int t_off);
        int m;
        int w;
        m = (t_on > t_off) ? t_on : t_off;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/exibe_sequencia_contador_tempo.sv
// -----------------------------------------------------------------------------
// contador_tempo
//   Modulo-M cycle counter. The terminal value (M-1) arrives on 'limite' so the
//   parent can share one counter between phases of different lengths.
// Ports
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   zera    in   synchronous clear (wins over conta)
//   conta   in   count enable
//   limite  in   terminal value M-1; counter returns to 0 after it
//   valor   out  current count
//   fim     out  high while counting and valor == limite
// -----------------------------------------------------------------------------
module contador_tempo #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    input  logic [W-1:0] limite,
    output logic [W-1:0] valor,
    output logic         fim
);

    logic [W-1:0] valor_q;

    assign valor = valor_q;
    assign fim   = conta && (valor_q == limite);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor_q <= '0;
        end else if (zera) begin
            valor_q <= '0;
        end else if (conta) begin
            if (valor_q == limite) begin
                valor_q <= '0;
            end else if (valor_q != {W{1'b1}}) begin
                // saturate instead of wrapping if limite were ever out of range
                valor_q <= valor_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/exibe_sequencia.sv
// -----------------------------------------------------------------------------
// exibe_sequencia
//   Presents positions 0..rodada of the sequence ROM on the LEDs before a round:
//   each value is lit for T_ON cycles then blanked for T_OFF cycles. pronto
//   pulses for one cycle when the presentation ends.
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   iniciar   in   start request, only sampled while idle
//   rodada    in   index of last position shown, captured with iniciar
//   dado      in   ROM read data (one cycle after endereco)
//   endereco  out  ROM address
//   leds      out  value shown, zero outside MOSTRA
//   exibindo  out  high in every state except OCIOSO and FIM
//   pronto    out  one-cycle pulse in FIM
//   db_estado out  current state code
// -----------------------------------------------------------------------------
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] rodada,
    input  logic [DATA_W-1:0] dado,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam int TW = largura_timer(T_ON, T_OFF);

    estado_t           estado_q;
    logic [ADDR_W-1:0] endereco_q;
    logic [ADDR_W-1:0] rodada_q;

    logic          timer_zera;
    logic          timer_conta;
    logic [TW-1:0] timer_limite;
    logic [TW-1:0] timer_valor;
    logic          timer_fim;

    // The timer only runs in the two timed phases; elsewhere it is held at 0
    assign timer_conta  = (estado_q == MOSTRA) || (estado_q == APAGA);
    assign timer_zera   = !timer_conta;
    assign timer_limite = (estado_q == MOSTRA) ? TW'(T_ON - 1) : TW'(T_OFF - 1);

    contador_tempo #(
        .W (TW)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .zera   (timer_zera),
        .conta  (timer_conta),
        .limite (timer_limite),
        .valor  (timer_valor),
        .fim    (timer_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            rodada_q   <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        estado_q   <= CARREGA;
                        rodada_q   <= rodada;
                        endereco_q <= '0;
                    end
                end
                // one cycle for the ROM to present dado for the new address
                CARREGA: estado_q <= MOSTRA;
                MOSTRA: begin
                    if (timer_fim) begin
                        estado_q <= APAGA;
                    end
                end
                APAGA: begin
                    if (timer_fim) begin
                        // stop on the last position so endereco never wraps
                        estado_q <= (endereco_q == rodada_q) ? FIM : PROXIMO;
                    end
                end
                PROXIMO: begin
                    endereco_q <= endereco_q + 1'b1;
                    estado_q   <= CARREGA;
                end
                FIM:     estado_q <= OCIOSO;
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    // Moore decode of the registered state
    always_comb begin
        leds      = '0;
        exibindo  = 1'b0;
        pronto    = 1'b0;
        db_estado = EST_INVALIDO;
        case (estado_q)
            OCIOSO:  db_estado = 4'h0;
            CARREGA: begin db_estado = 4'h1; exibindo = 1'b1; end
            MOSTRA:  begin db_estado = 4'h2; exibindo = 1'b1; leds = dado; end
            APAGA:   begin db_estado = 4'h3; exibindo = 1'b1; end
            PROXIMO: begin db_estado = 4'h4; exibindo = 1'b1; end
            FIM:     begin db_estado = 4'hF; pronto = 1'b1; end
            default: db_estado = EST_INVALIDO;
        endcase
    end

    assign endereco = endereco_q;

    // timer_valor is only consumed through timer_fim inside the counter
    logic unused_timer;
    assign unused_timer = ^timer_valor;

endmodule

// File: tb/tb_exibe_sequencia.sv
module tb_exibe_sequencia;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int T_ON   = 4;
    localparam int T_OFF  = 2;

    logic              clock;
    logic              reset;
    logic              iniciar;
    logic [ADDR_W-1:0] rodada;
    logic [DATA_W-1:0] dado;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] leds;
    logic              exibindo;
    logic              pronto;
    logic [3:0]        db_estado;

    // observed tuple per cycle: leds, pronto, exibindo, endereco, state
    typedef struct packed {
        logic [3:0] leds;
        logic       pronto;
        logic       exib;
        logic [3:0] addr;
        logic [3:0] est;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    exibe_sequencia #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .T_ON   (T_ON),
        .T_OFF  (T_OFF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .rodada    (rodada),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .exibindo  (exibindo),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // sequence ROM 1,2,4,8,1,2,... with one-cycle read latency
    function automatic logic [3:0] rom_val(input logic [3:0] a);
        return 4'(1 << a[1:0]);
    endfunction

    always @(posedge clock) dado <= rom_val(endereco);

    function automatic obs_t mk(input int l, input int p, input int e, input int a, input int s);
        obs_t o;
        o.leds   = 4'(l);
        o.pronto = 1'(p);
        o.exib   = 1'(e);
        o.addr   = 4'(a);
        o.est    = 4'(s);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.leds   = leds;
        o.pronto = pronto;
        o.exib   = exibindo;
        o.addr   = endereco;
        o.est    = db_estado;
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        total++;
        assert (act === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, act, expv);
        end
    endtask

    // Expected cycle-by-cycle trace of a presentation of positions 0..r
    task automatic build_expected(input int r);
        exp_q.delete();
        exp_q.push_back(mk(0, 0, 1, 0, 1));
        for (int i = 0; i <= r; i++) begin
            for (int k = 0; k < T_ON; k++)  exp_q.push_back(mk(rom_val(4'(i)), 0, 1, i, 2));
            for (int k = 0; k < T_OFF; k++) exp_q.push_back(mk(0, 0, 1, i, 3));
            if (i < r) begin
                exp_q.push_back(mk(0, 0, 1, i, 4));
                exp_q.push_back(mk(0, 0, 1, i + 1, 1));
            end else begin
                exp_q.push_back(mk(0, 1, 0, i, 15));
            end
        end
    endtask

    // glitch_cyc: cycle at which iniciar pulses and rodada changes to 5
    // reset_cyc : cycle at which reset is asserted (presentation aborted)
    task automatic present(input int r, input int glitch_cyc, input int reset_cyc, input bit hold);
        int   cyc;
        obs_t e;
        build_expected(r);
        $display("txn start rodada=%0d expected_cycles=%0d", r, exp_q.size());
        @(negedge clock);
        rodada  = 4'(r);
        iniciar = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            cyc++;
            if (!hold) iniciar = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("r%0d_cyc%0d", r, cyc), 32'(sample()), 32'(e));
            if (cyc == glitch_cyc) begin
                iniciar = 1'b1;
                rodada  = 4'd5;
            end
            if (cyc == glitch_cyc + 1) iniciar = 1'b0;
            if (cyc == reset_cyc) begin
                reset = 1'b0;
                #1;
                check("abort_state", 32'(sample()), 32'(mk(0, 0, 0, 0, 0)));
                for (int k = 0; k < 2; k++) begin
                    @(negedge clock);
                    check("abort_no_pronto", 32'(pronto), 32'd0);
                end
                reset = 1'b1;
                exp_q.delete();
            end
        end
        $display("txn end rodada=%0d cycles=%0d bad=%0d", r, cyc, bad);
    endtask

    initial begin
        bit found;
        reset   = 1'b0;
        iniciar = 1'b0;
        rodada  = '0;

        // 1. reset values
        repeat (3) @(negedge clock);
        check("rst_state_held", 32'(sample()), 32'(mk(0, 0, 0, 0, 0)));
        reset = 1'b1;
        @(negedge clock);
        check("rst_state_after", 32'(sample()), 32'(mk(0, 0, 0, 0, 0)));

        // 2. single value
        present(0, -1, -1, 1'b0);
        @(negedge clock);
        check("idle_after_r0", 32'(db_estado), 32'd0);

        // 3. three values
        present(2, -1, -1, 1'b0);

        // 4. iniciar and rodada change during MOSTRA are ignored
        present(2, 3, -1, 1'b0);
        @(negedge clock);
        check("idle_after_glitch", 32'(db_estado), 32'd0);

        // 5. reset during second MOSTRA
        present(2, -1, 11, 1'b0);

        // 6. full sequence with iniciar held: restarts right after FIM
        present(15, -1, -1, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            @(negedge clock);
            if (db_estado == 4'h1) found = 1'b1;
        end
        check("restart_carrega", 32'(found), 32'd1);
        check("restart_addr0", 32'(endereco), 32'd0);
        iniciar = 1'b0;
        reset   = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("final_idle", 32'(sample()), 32'(mk(0, 0, 0, 0, 0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
